// File: rtl/seg7_pkg.sv
// Shared types, constants and hex decoder for the seven-segment scan controller.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } seg7_frame_t;

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_pwm_timer.sv
// Slot/slot_cnt scan timer: selects the current digit, its PWM window and the frame boundary.
module seg7_pwm_timer #(
  parameter int SCAN_DIV = 131072
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bright,
  output logic [1:0] slot,
  output logic       lit_window,
  output logic       frame_boundary
);

  localparam int PWM_STEP = SCAN_DIV / 16;
  localparam int CNT_W    = $clog2(SCAN_DIV);
  localparam int LIM_W    = CNT_W + 1;

  logic [CNT_W-1:0] slot_cnt_reg;
  logic [1:0]       slot_reg;
  logic             slot_end;
  logic [LIM_W-1:0] lit_limit;

  assign slot_end = (slot_cnt_reg == CNT_W'(SCAN_DIV - 1));
  // One extra bit so bright=15 yields a limit of SCAN_DIV (always lit).
  assign lit_limit = LIM_W'((32'(bright) + 32'd1) * 32'(PWM_STEP));

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_reg <= '0;
      slot_reg     <= '0;
    end else if (slot_end) begin
      slot_cnt_reg <= '0;
      slot_reg     <= slot_reg + 2'd1;
    end else begin
      slot_cnt_reg <= slot_cnt_reg + 1'b1;
    end
  end

  assign slot           = slot_reg;
  assign lit_window     = ({1'b0, slot_cnt_reg} < lit_limit);
  assign frame_boundary = slot_end && (slot_reg == 2'd3);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Double-buffered 4-digit seven-segment scan controller with PWM brightness.
// Optional leading-zero auto-blanking: define SEG7_LEAD_ZERO_BLANK_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 131072
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [15:0]           wr_digits,
  input  logic [3:0]            wr_dp,
  input  logic [3:0]            wr_blank,
  input  logic [3:0]            bright,
  output logic                  frame_tick,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg
);

  logic        pending_reg;
  seg7_frame_t shadow_reg;
  seg7_frame_t active_reg;
  seg7_frame_t transfer_frame;
  logic [NUM_DIGITS-1:0] an_reg;
  logic [7:0]  seg_reg;
  logic        frame_tick_reg;

  logic [1:0]  slot;
  logic        lit_window;
  logic        frame_boundary;
  logic        accept;
  logic        lit;
  logic [3:0]  cur_digit;
  logic [NUM_DIGITS-1:0] lead_zero_mask;

  seg7_pwm_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk            (clk),
    .reset          (reset),
    .bright         (bright),
    .slot           (slot),
    .lit_window     (lit_window),
    .frame_boundary (frame_boundary)
  );

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:1] digit_zero;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_zero
    assign digit_zero[gi] = (shadow_reg.digits[4*gi +: 4] == 4'h0) && !shadow_reg.dp[gi];
  end
  // A digit is a leading zero only if it and every digit above it are empty.
  assign lead_zero_mask = {digit_zero[3], &digit_zero[3:2], &digit_zero[3:1], 1'b0};
`else
  assign lead_zero_mask = '0;
`endif

  always_comb begin
    transfer_frame       = shadow_reg;
    transfer_frame.blank = shadow_reg.blank | lead_zero_mask;
  end

  assign wr_ready  = ~pending_reg & ~reset;
  assign accept    = wr_valid & wr_ready;
  assign cur_digit = active_reg.digits[{slot, 2'b00} +: 4];
  assign lit       = lit_window && !active_reg.blank[slot];

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg    <= 1'b0;
      shadow_reg     <= '0;
      active_reg     <= '{digits: 16'h0000, dp: 4'h0, blank: 4'hF};
      an_reg         <= AN_OFF;
      seg_reg        <= SEG_OFF;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= frame_boundary;
      // Transfer needs pending=1 and accept needs pending=0, so these never collide.
      if (frame_boundary && pending_reg) begin
        active_reg  <= transfer_frame;
        pending_reg <= 1'b0;
      end else if (accept) begin
        shadow_reg  <= '{digits: wr_digits, dp: wr_dp, blank: wr_blank};
        pending_reg <= 1'b1;
      end
      if (lit) begin
        an_reg  <= ~(NUM_DIGITS'(1) << slot);
        seg_reg <= {~active_reg.dp[slot], hex_to_seg(cur_digit)};
      end else begin
        an_reg  <= AN_OFF;
        seg_reg <= SEG_OFF;
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-level reference model queues expected outputs.
module tb_seg7_scan_ctrl;

  localparam int SCAN_DIV = 32;
  localparam int PWM_STEP = SCAN_DIV / 16;
  localparam int FRAME    = 4 * SCAN_DIV;

  // Lit segments per hex value, active-high, bit order g..a.
  localparam logic [6:0] LIT_SEGS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_digits = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  wr_blank = '0;
  logic [3:0]  bright = 4'd15;
  logic        wr_ready;
  logic        frame_tick;
  logic [3:0]  an;
  logic [7:0]  seg;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_digits  (wr_digits),
    .wr_dp      (wr_dp),
    .wr_blank   (wr_blank),
    .bright     (bright),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg)
  );

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic       tick;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: elapsed cycles since reset plus the two frame buffers.
  int          m_t = 0;
  bit          m_pending = 0;
  logic [15:0] sh_d = '0, act_d = '0;
  logic [3:0]  sh_dp = '0, act_dp = '0, sh_bl = '0, act_bl = 4'hF;

  function automatic logic [3:0] auto_blank(input logic [15:0] d, input logic [3:0] dp);
    int top_k = 0;
    logic [3:0] m = '0;
    for (int k = 0; k < 4; k++)
      if (d[4*k +: 4] != 4'h0 || dp[k]) top_k = k;
    for (int k = 1; k < 4; k++)
      if (k > top_k) m[k] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    int   cnt, sl;
    bit   lit, bnd;
    cnt = m_t % SCAN_DIV;
    sl  = (m_t / SCAN_DIV) % 4;
    bnd = (m_t % FRAME) == FRAME - 1;
    if (reset) begin
      m_t = 0;
      m_pending = 0;
      act_d = '0; act_dp = '0; act_bl = 4'hF;
      e = '{an: 4'hF, seg: 8'hFF, tick: 1'b0, ready: 1'b0};
    end else begin
      lit = (cnt < (int'(bright) + 1) * PWM_STEP) && !act_bl[sl];
      e.an  = 4'hF;
      e.seg = 8'hFF;
      if (lit) begin
        e.an[sl]    = 1'b0;
        e.seg[6:0]  = ~LIT_SEGS[act_d[4*sl +: 4]];
        e.seg[7]    = ~act_dp[sl];
      end
      e.tick = bnd;
      if (bnd && m_pending) begin
        act_d = sh_d; act_dp = sh_dp; act_bl = sh_bl;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        act_bl = act_bl | auto_blank(sh_d, sh_dp);
`endif
        m_pending = 0;
        $display("t=%0t frame shown digits=%h dp=%b blank=%b", $time, act_d, act_dp, act_bl);
      end else if (wr_valid && !m_pending) begin
        sh_d = wr_digits; sh_dp = wr_dp; sh_bl = wr_blank;
        m_pending = 1;
        $display("t=%0t write accepted digits=%h dp=%b blank=%b", $time, wr_digits, wr_dp, wr_blank);
      end
      m_t++;
      e.ready = !m_pending;
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL queue_empty t=%0t got=0 want=1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("an", {4'h0, an}, {4'h0, e.an});
      chk("seg", seg, e.seg);
      chk("frame_tick", {7'h0, frame_tick}, {7'h0, e.tick});
      chk("wr_ready", {7'h0, wr_ready}, {7'h0, e.ready});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != ph; i++) @(negedge clk);
  endtask

  task automatic write_frame(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    int waited = 0;
    @(negedge clk);
    wr_digits = d; wr_dp = dp; wr_blank = bl; wr_valid = 1'b1;
    while (!wr_ready && waited < 3 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    if (waited >= 3 * FRAME) begin
      total++;
      bad++;
      $display("FAIL write_timeout t=%0t got=%0d want<%0d", $time, waited, 3 * FRAME);
    end
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    idle(FRAME);                                  // blank display, ticks every frame

    write_frame(16'h1234, 4'b0100, 4'b0000);
    idle(2 * FRAME);
    bright = 4'd3;
    idle(FRAME);
    bright = 4'd15;

    // Offer while pending (ignored), then land a write on the boundary cycle.
    wait_phase(0);
    write_frame(16'h5A6B, 4'b0011, 4'b0000);
    @(negedge clk);
    wr_digits = 16'hDEAD; wr_dp = 4'hF; wr_valid = 1'b1;
    idle(10);
    wr_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME && m_pending; i++) @(negedge clk);
    idle(2);
    wait_phase(FRAME - 1);
    wr_digits = 16'hC0FE; wr_dp = 4'b1000; wr_blank = 4'b0010; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    idle(3 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) bright = 4'($urandom_range(0, 15));
      wr_valid  = ($urandom_range(0, 3) == 0);
      wr_digits = 16'($urandom);
      wr_dp     = 4'($urandom);
      wr_blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    bright = 4'd15;
    idle(2 * FRAME);

    // Reset at slot 2 with a pending write; that frame must never appear.
    wait_phase(0);
    write_frame(16'hABCD, 4'b1111, 4'b0000);
    for (int i = 0; i < 2 * FRAME && ((m_t / SCAN_DIV) % 4) != 2; i++) @(negedge clk);
    idle(3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2 * FRAME);

    write_frame(16'h0050, 4'b0000, 4'b0000);
    idle(2 * FRAME);
    write_frame(16'h0000, 4'b0000, 4'b0000);
    idle(2 * FRAME);
    write_frame(16'h0300, 4'b0000, 4'b0000);
    idle(2 * FRAME);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
